// File: rtl/sram_ppm_uart_tx_pkg.sv
// project_pkg: shared definitions for the SRAM-to-UART PPM frame dumper.
//   - state_t      : frame dump controller states
//   - hdr_byte()   : 15-entry PPM header table "P6\n320 240\n255\n"
//   - DEF_*        : default parameter values
//   - *_W          : fixed datapath widths
package project_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;     // 50 MHz / 115200 baud
  localparam int DEF_NUM_WORDS    = 115200;  // 3*320*240/2 words
  localparam int DEF_SEND_HEADER  = 1;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 16;
  localparam int WCNT_W    = 17;
  localparam int HDR_LEN   = 15;
  localparam int HDR_CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_REQ,
    S_WAIT1,
    S_WAIT2,
    S_SEND_HI,
    S_SEND_LO,
    S_DONE
  } state_t;

  // PPM binary header for a 320x240, 8-bit-per-channel image.
  function automatic logic [7:0] hdr_byte(input logic [HDR_CNT_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h50;  // 'P'
      4'd1:    b = 8'h36;  // '6'
      4'd2:    b = 8'h0A;
      4'd3:    b = 8'h33;  // '3'
      4'd4:    b = 8'h32;  // '2'
      4'd5:    b = 8'h30;  // '0'
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h32;  // '2'
      4'd8:    b = 8'h34;  // '4'
      4'd9:    b = 8'h30;  // '0'
      4'd10:   b = 8'h0A;
      4'd11:   b = 8'h32;  // '2'
      4'd12:   b = 8'h35;  // '5'
      4'd13:   b = 8'h35;  // '5'
      4'd14:   b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sram_ppm_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser.
//   Clock_50   in  : clock
//   Reset      in  : async active-high reset, line forced high
//   Tx_start   in  : load Tx_data and begin a frame (honoured when !Tx_busy)
//   Tx_data    in  : byte to send, LSB first
//   Tx_busy    out : frame in progress; drops during the final stop-bit cycle
//   UART_TX_O  out : serial line, idle high
// Tx_busy deasserts one cycle early so a Tx_start issued in the last stop-bit
// cycle puts the next start bit on the line with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock_50,
  input  logic       Reset,
  input  logic       Tx_start,
  input  logic [7:0] Tx_data,
  output logic       Tx_busy,
  output logic       UART_TX_O
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;   // 0 start, 1..8 data, 9 stop
  logic [7:0]    data_q;
  logic          bit_end;
  logic          last_cyc;

  assign bit_end  = (clk_cnt == CNT_LAST);
  assign last_cyc = active && (bit_idx == 4'd9) && bit_end;
  assign Tx_busy  = active && !last_cyc;

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      active    <= 1'b0;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      UART_TX_O <= 1'b1;
    end else if (Tx_start && !Tx_busy) begin
      active    <= 1'b1;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      data_q    <= Tx_data;
      UART_TX_O <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        clk_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active    <= 1'b0;
          UART_TX_O <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          // Next bit is data[bit_idx] (index k holds data[k-1]), or stop after bit 8.
          UART_TX_O <= (bit_idx == 4'd8) ? 1'b1 : data_q[bit_idx[2:0]];
        end
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sram_ppm_uart_tx.sv
// sram_ppm_uart_tx: streams an RGB frame from SRAM out of a UART as a PPM file.
//   Clock_50        in  : clock
//   Reset           in  : async active-high reset
//   Start           in  : pulse to begin a dump (ignored while Busy)
//   Base_address    in  : first SRAM word, latched on accepted Start
//   SRAM_address    out : read address, valid during S_REQ, held otherwise
//   SRAM_read_data  in  : read data, valid two cycles after the address
//   SRAM_we_n       out : tied inactive (read only)
//   UART_TX_O       out : 8N1 serial line
//   Busy            out : dump in progress
//   Done            out : one-cycle pulse after the final stop bit
// Each word is sent high byte first. The next word's read starts only once the
// low byte has fully left the line, so words are separated by the read latency;
// header bytes and the two bytes of a word run back to back.
module sram_ppm_uart_tx
  import project_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int NUM_WORDS    = DEF_NUM_WORDS,
  parameter int SEND_HEADER  = DEF_SEND_HEADER
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_address,
  output logic [ADDR_W-1:0] SRAM_address,
  input  logic [DATA_W-1:0] SRAM_read_data,
  output logic              SRAM_we_n,
  output logic              UART_TX_O,
  output logic              Busy,
  output logic              Done
);

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      base_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [ADDR_W-1:0]      rd_addr;
  logic [WCNT_W-1:0]      word_cnt;
  logic [WCNT_W-1:0]      word_cnt_inc;
  logic [HDR_CNT_W-1:0]   hdr_cnt;
  logic [DATA_W-1:0]      hold_q;
  logic                   lo_sent;   // low byte handed to the serialiser
  logic                   last_word;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   tx_busy;

  assign SRAM_we_n    = 1'b1;
  assign rd_addr      = base_q + {1'b0, word_cnt};   // wraps at 18 bits
  assign word_cnt_inc = word_cnt + WCNT_W'(1);
  assign last_word    = (word_cnt_inc == WCNT_W'(NUM_WORDS));

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .Clock_50  (Clock_50),
    .Reset     (Reset),
    .Tx_start  (tx_start),
    .Tx_data   (tx_data),
    .Tx_busy   (tx_busy),
    .UART_TX_O (UART_TX_O)
  );

  // State register
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (Start) state_nxt = (SEND_HEADER != 0) ? S_HEADER : S_REQ;
      S_HEADER:  if (!tx_busy && hdr_cnt == HDR_CNT_W'(HDR_LEN - 1)) state_nxt = S_REQ;
      S_REQ:     state_nxt = S_WAIT1;
      S_WAIT1:   state_nxt = S_WAIT2;
      S_WAIT2:   state_nxt = S_SEND_HI;
      S_SEND_HI: if (!tx_busy) state_nxt = S_SEND_LO;
      // Second !tx_busy is the low byte's final stop-bit cycle.
      S_SEND_LO: if (!tx_busy && lo_sent) state_nxt = last_word ? S_DONE : S_REQ;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx_start     = 1'b0;
    tx_data      = '0;
    Busy         = 1'b1;
    Done         = 1'b0;
    SRAM_address = addr_q;
    case (state)
      S_IDLE:    Busy = 1'b0;
      S_HEADER:  begin
        tx_start = !tx_busy;
        tx_data  = hdr_byte(hdr_cnt);
      end
      S_REQ:     SRAM_address = rd_addr;
      S_SEND_HI: begin
        tx_start = !tx_busy;
        tx_data  = hold_q[15:8];
      end
      S_SEND_LO: begin
        tx_start = !tx_busy && !lo_sent;
        tx_data  = hold_q[7:0];
      end
      S_DONE:    begin
        Busy = 1'b0;
        Done = 1'b1;
      end
      default:   ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      base_q   <= '0;
      addr_q   <= '0;
      word_cnt <= '0;
      hdr_cnt  <= '0;
      hold_q   <= '0;
      lo_sent  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          base_q   <= Base_address;
          word_cnt <= '0;
          hdr_cnt  <= '0;
          lo_sent  <= 1'b0;
        end
        S_HEADER:  if (!tx_busy) hdr_cnt <= hdr_cnt + HDR_CNT_W'(1);
        S_REQ:     addr_q <= rd_addr;
        S_WAIT2:   hold_q <= SRAM_read_data;
        S_SEND_LO: if (!tx_busy) begin
          lo_sent <= !lo_sent;
          if (lo_sent) word_cnt <= word_cnt_inc;
        end
        default:   ;
      endcase
    end
  end

endmodule
